// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the uart_hub echo path: pacer FSM state encodings,
//   default FIFO depth and the byte width used by uart_byte_fifo and its RAM.
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int FIFO_DEPTH_DEFAULT = 16;
    localparam int BYTE_W             = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_RDY  = 2'd2
    } pacer_state_t;

endpackage : uart_pkg

// File: rtl/uart_fifo_mem.sv
// ---------------------------------------------------------------------------
// uart_fifo_mem
//   Simple dual-port DEPTH x 8 RAM with a registered, enabled read port,
//   written so that it maps onto iCE40 block RAM.
// Ports
//   clk    system clock
//   rst    synchronous active-high reset (clears the read register only)
//   we     write enable
//   waddr  write address
//   wdata  write data
//   re     read enable; rdata holds its value while re = 0
//   raddr  read address
//   rdata  registered read data (old contents on a same-address write)
// ---------------------------------------------------------------------------
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter  int DEPTH = FIFO_DEPTH_DEFAULT,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [BYTE_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [BYTE_W-1:0] rdata
);

    logic [BYTE_W-1:0] ram [DEPTH];

    // NOTE: the storage array is deliberately left without reset; a reset
    // port on the array would stop it mapping to block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            ram[waddr] <= wdata;
        end
    end

    // Read-before-write: a full FIFO popping and accepting in the same cycle
    // reads the outgoing byte while the incoming one lands at the same slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= ram[raddr];
        end
    end

endmodule : uart_fifo_mem

// File: rtl/uart_byte_fifo.sv
// ---------------------------------------------------------------------------
// uart_byte_fifo
//   Byte FIFO and transmit pacer between uart_rx and uart_tx. Bytes strobed
//   in from the receiver are queued and handed to the transmitter one at a
//   time through its new_data/rdy handshake.
// Ports
//   clk          system clock
//   rst          synchronous active-high reset
//   wr_stb       one-cycle strobe, wr_data valid
//   wr_data      byte to enqueue
//   tx_rdy       transmitter ready
//   tx_new_data  one-cycle issue pulse to the transmitter
//   tx_char      byte being transmitted; changes only on an issue edge
//   count        occupancy 0..DEPTH
//   empty/full   registered occupancy flags
//   overflow     sticky: a write was dropped since reset
//   ovf_count    dropped-byte counter, saturating at 8'hFF
// Build option
//   UART_FIFO_OVF_COUNT_EN  when defined, ovf_count counts dropped writes;
//                           otherwise it is tied to zero.
// ---------------------------------------------------------------------------
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter  int DEPTH   = FIFO_DEPTH_DEFAULT,
    parameter  int HOLDOFF = 4,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_stb,
    input  logic [BYTE_W-1:0] wr_data,
    input  logic              tx_rdy,
    output logic              tx_new_data,
    output logic [BYTE_W-1:0] tx_char,
    output logic [AW:0]       count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic [7:0]        ovf_count
);

    localparam int          HW        = $clog2(HOLDOFF);
    localparam logic [AW:0] FULL_CNT  = (AW+1)'(DEPTH);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF - 1);

    pacer_state_t  state, state_next;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [HW-1:0] hold_cnt;
    logic [AW:0]   count_next;
    logic          pop, accept, drop;

    // ---------------- state register ----------------
    // NOTE: all sequential state uses non-blocking assignment so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- next-state logic ----------------
    // NOTE: state_next is defaulted before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (!empty && tx_rdy) state_next = WAIT_BUSY;
            WAIT_BUSY: begin
                // tx may take the byte without ever dropping rdy; the holdoff
                // bounds how long we wait to see it go busy.
                if (!tx_rdy)                    state_next = WAIT_RDY;
                else if (hold_cnt == HOLD_LAST) state_next = IDLE;
            end
            WAIT_RDY:  if (tx_rdy) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // ---------------- output / control logic ----------------
    always_comb begin
        pop    = (state == IDLE) && !empty && tx_rdy;
        // A full FIFO still accepts when a byte leaves in the same cycle.
        accept = wr_stb && (!full || pop);
        drop   = wr_stb && !accept;
        count_next = count;
        if (accept && !pop)      count_next = count + 1'b1;
        else if (!accept && pop) count_next = count - 1'b1;
    end

    // Holdoff counter clears on entry to WAIT_BUSY (the pop edge).
    always_ff @(posedge clk) begin
        if (rst || pop) begin
            hold_cnt <= '0;
        end else if (state == WAIT_BUSY && hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

    // ---------------- pointers, flags, issue pulse ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            empty       <= 1'b1;
            full        <= 1'b0;
            overflow    <= 1'b0;
            tx_new_data <= 1'b0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;   // wraps modulo DEPTH
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
            count       <= count_next;
            empty       <= (count_next == '0);
            full        <= (count_next == FULL_CNT);
            if (drop)   overflow <= 1'b1;
            tx_new_data <= pop;
        end
    end

    // The RAM read register is tx_char: it loads only on a pop, so the
    // character stays put between issues and clears on reset.
    uart_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (accept),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .re    (pop),
        .raddr (rd_ptr),
        .rdata (tx_char)
    );

`ifdef UART_FIFO_OVF_COUNT_EN
    logic [7:0] ovf_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_cnt_q <= '0;
        end else if (drop && ovf_cnt_q != 8'hFF) begin
            ovf_cnt_q <= ovf_cnt_q + 1'b1;
        end
    end

    assign ovf_count = ovf_cnt_q;
`else
    assign ovf_count = 8'h00;
`endif

endmodule : uart_byte_fifo

// File: tb/tb_uart_byte_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_byte_fifo
//   Directed stimulus for uart_byte_fifo with a queue-based reference model
//   checked on every clock, plus literal expectations per scenario.
// ---------------------------------------------------------------------------
module tb_uart_byte_fifo;

    localparam int DEPTH   = 16;
    localparam int HOLDOFF = 4;
    localparam int AW      = $clog2(DEPTH);
`ifdef UART_FIFO_OVF_COUNT_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic        wr_stb   = 1'b0;
    logic [7:0]  wr_data  = 8'h00;
    logic        dir_rdy  = 1'b0;
    logic        emu_mode = 1'b0;
    logic        emu_rdy  = 1'b1;
    int          emu_busy = 0;
    logic        tx_rdy;
    logic        tx_new_data;
    logic [7:0]  tx_char;
    logic [AW:0] count;
    logic        empty, full, overflow;
    logic [7:0]  ovf_count;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [7:0] q[$];
    logic [7:0] m_char;
    bit         m_ovf;
    int         m_ovf_cnt;
    int         cyc = 0;
    int         last_issue = -100;
    bit         model_live = 1'b0;
    logic [7:0] pulse_data[$];
    int         pulse_cyc[$];

    assign tx_rdy = emu_mode ? emu_rdy : dir_rdy;

    always #5 clk = ~clk;

    uart_byte_fifo #(
        .DEPTH   (DEPTH),
        .HOLDOFF (HOLDOFF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_stb      (wr_stb),
        .wr_data     (wr_data),
        .tx_rdy      (tx_rdy),
        .tx_new_data (tx_new_data),
        .tx_char     (tx_char),
        .count       (count),
        .empty       (empty),
        .full        (full),
        .overflow    (overflow),
        .ovf_count   (ovf_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transmitter emulation: goes busy for 160 cycles after each pulse.
    always @(negedge clk) begin
        if (tx_new_data === 1'b1) emu_busy = 160;
        else if (emu_busy > 0)    emu_busy = emu_busy - 1;
        emu_rdy = (emu_busy == 0);
    end

    // Per-cycle compare against the queue model. The model does not decide
    // when an issue happens; it checks that every observed issue is legal
    // (byte available, tx ready, spacing) and carries the head byte.
    always @(posedge clk) begin : cmp
        logic       s_rst, s_stb, s_rdy;
        logic [7:0] s_data;
        bit         pop_obs, full_before, acc;
        s_rst  = rst;
        s_stb  = wr_stb;
        s_rdy  = tx_rdy;
        s_data = wr_data;
        #1;
        cyc++;
        if (s_rst) begin
            q.delete();
            m_ovf      = 1'b0;
            m_ovf_cnt  = 0;
            m_char     = 8'h00;
            last_issue = -100;
            model_live = 1'b1;
            check("rst_no_pulse", 32'(tx_new_data), 32'd0);
        end else if (model_live) begin
            pop_obs     = (tx_new_data === 1'b1);
            full_before = (q.size() == DEPTH);
            if (pop_obs) begin
                check("issue_has_byte", 32'(q.size() != 0), 32'd1);
                check("issue_tx_rdy", 32'(s_rdy), 32'd1);
                check("issue_spacing", 32'(cyc - last_issue >= 3), 32'd1);
                if (q.size() != 0) begin
                    check("issue_data", 32'(tx_char), 32'(q[0]));
                    m_char = q.pop_front();
                end
                last_issue = cyc;
                pulse_data.push_back(tx_char);
                pulse_cyc.push_back(cyc);
            end
            acc = s_stb && (!full_before || pop_obs);
            if (acc) begin
                q.push_back(s_data);
            end else if (s_stb) begin
                m_ovf = 1'b1;
                if (OVF_EN && m_ovf_cnt < 255) m_ovf_cnt++;
            end
        end
        if (model_live) begin
            check("count", 32'(count), 32'(q.size()));
            check("empty", 32'(empty), 32'(q.size() == 0));
            check("full", 32'(full), 32'(q.size() == DEPTH));
            check("overflow", 32'(overflow), 32'(m_ovf));
            check("ovf_count", 32'(ovf_count), 32'(m_ovf_cnt));
            check("tx_char_hold", 32'(tx_char), 32'(m_char));
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst    = 1'b1;
        wr_stb = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic write_burst(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            wr_stb  = 1'b1;
            wr_data = first + 8'(i);
        end
        @(negedge clk);
        wr_stb = 1'b0;
    endtask

    task automatic wait_pulses(input int target, input int budget, input string name);
        for (int i = 0; i < budget && pulse_data.size() < target; i++) @(negedge clk);
        check(name, 32'(pulse_data.size()), 32'(target));
    endtask

    initial begin
        int mark;

        // 1: single byte, immediate issue
        dir_rdy = 1'b1;
        do_reset();
        check("t1_rst_count", 32'(count), 32'd0);
        check("t1_rst_empty", 32'(empty), 32'd1);
        check("t1_rst_char", 32'(tx_char), 32'h00);
        @(negedge clk);
        wr_stb  = 1'b1;
        wr_data = 8'h41;
        @(posedge clk); #2;
        check("t1_count_1", 32'(count), 32'd1);
        check("t1_no_pulse_yet", 32'(tx_new_data), 32'd0);
        @(negedge clk);
        wr_stb = 1'b0;
        @(posedge clk); #2;
        check("t1_pulse", 32'(tx_new_data), 32'd1);
        check("t1_char", 32'(tx_char), 32'h41);
        check("t1_count_0", 32'(count), 32'd0);
        check("t1_empty", 32'(empty), 32'd1);
        @(posedge clk); #2;
        check("t1_pulse_1cyc", 32'(tx_new_data), 32'd0);

        // 2: fill while tx busy, then overflow
        dir_rdy = 1'b0;
        do_reset();
        write_burst(8'h00, 16);
        check("t2_full", 32'(full), 32'd1);
        check("t2_count", 32'(count), 32'd16);
        check("t2_no_ovf", 32'(overflow), 32'd0);
        write_burst(8'hEE, 1);
        check("t2_ovf", 32'(overflow), 32'd1);
        check("t2_ovf_cnt", 32'(ovf_count), OVF_EN ? 32'd1 : 32'd0);
        check("t2_count_after", 32'(count), 32'd16);

        // 3: drain through the emulated transmitter
        mark = pulse_data.size();
        emu_mode = 1'b1;
        wait_pulses(mark + 16, 4000, "t3_pulse_cnt");
        for (int i = 0; i < 16; i++) begin
            if (mark + i < pulse_data.size())
                check("t3_order", 32'(pulse_data[mark + i]), 32'(i));
        end
        repeat (400) @(negedge clk);
        check("t3_no_extra", 32'(pulse_data.size()), 32'(mark + 16));
        check("t3_empty", 32'(empty), 32'd1);

        // 4: write into full FIFO on the issue edge
        emu_mode = 1'b0;
        dir_rdy  = 1'b0;
        do_reset();
        write_burst(8'h10, 16);
        mark = pulse_data.size();
        @(negedge clk);
        wr_stb  = 1'b1;
        wr_data = 8'h99;
        dir_rdy = 1'b1;
        @(posedge clk); #2;
        check("t4_pulse", 32'(tx_new_data), 32'd1);
        check("t4_char", 32'(tx_char), 32'h10);
        check("t4_count", 32'(count), 32'd16);
        check("t4_no_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        wr_stb   = 1'b0;
        emu_mode = 1'b1;
        wait_pulses(mark + 17, 4000, "t4_pulse_cnt");
        if (pulse_data.size() == mark + 17) begin
            check("t4_first_15", 32'(pulse_data[mark + 15]), 32'h1F);
            check("t4_last", 32'(pulse_data[mark + 16]), 32'h99);
        end

        // 5: tx_rdy held high, pacing by holdoff alone
        emu_mode = 1'b0;
        dir_rdy  = 1'b0;
        do_reset();
        write_burst(8'hA0, 3);
        mark = pulse_data.size();
        dir_rdy = 1'b1;
        wait_pulses(mark + 3, 100, "t5_pulse_cnt");
        if (pulse_data.size() == mark + 3) begin
            check("t5_gap1", 32'(pulse_cyc[mark + 1] - pulse_cyc[mark]), 32'(HOLDOFF + 1));
            check("t5_gap2", 32'(pulse_cyc[mark + 2] - pulse_cyc[mark + 1]), 32'(HOLDOFF + 1));
            check("t5_data0", 32'(pulse_data[mark]), 32'hA0);
            check("t5_data2", 32'(pulse_data[mark + 2]), 32'hA2);
        end

        // 6: reset while waiting for tx ready
        dir_rdy = 1'b0;
        do_reset();
        write_burst(8'h50, 5);
        mark = pulse_data.size();
        dir_rdy = 1'b1;
        @(negedge clk);
        dir_rdy = 1'b0;
        repeat (2) @(negedge clk);
        check("t6_issued", 32'(pulse_data.size()), 32'(mark + 1));
        check("t6_count4", 32'(count), 32'd4);
        rst = 1'b1;
        @(posedge clk); #2;
        check("t6_rst_count", 32'(count), 32'd0);
        check("t6_rst_pulse", 32'(tx_new_data), 32'd0);
        @(negedge clk);
        rst     = 1'b0;
        dir_rdy = 1'b1;
        repeat (30) @(negedge clk);
        check("t6_quiet", 32'(pulse_data.size()), 32'(mark + 1));
        write_burst(8'h77, 1);
        wait_pulses(mark + 2, 10, "t6_new_pulse");
        if (pulse_data.size() == mark + 2)
            check("t6_new_data", 32'(pulse_data[mark + 1]), 32'h77);

        repeat (10) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_uart_byte_fifo
